hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage RV32I core; it sequences the pipeline registers around the EX-stage operand forwarding path.
- Detects load-use hazards that forwarding cannot cover, since load data is only forwardable from WB. It inserts one bubble for these.
- Flushes IF/ID and ID/EX on an EX-stage control-flow redirect.
- Freezes the whole pipeline while a MEM-stage data-memory access waits for its acknowledge, with a timeout.

Parameters:
MEM_TIMEOUT, 16, max wait cycles in MEM_WAIT before abort (>=2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
ID_rs1  in  5  source reg 1 of instruction in ID
ID_rs2  in  5  source reg 2 of instruction in ID
ID_ValidReg  in  3  [0] rd written, [1] rs1 used, [2] rs2 used (ID instr)
EX_rd  in  5  destination reg of instruction in EX
EX_ValidReg  in  3  same encoding, EX instr
EX_RegSrc  in  2  writeback source of EX instr; 1 = load data
EX_redirect  in  1  EX resolved taken branch/jump mispredict; PC loads target
MEM_dmem_req  in  1  MEM instr is accessing data memory this cycle
dmem_ack  in  1  data memory completes access (same-cycle ack allowed)
pc_stall  out  1  hold PC
IFID_stall  out  1  hold IF/ID register
IFID_flush  out  1  load NOP into IF/ID
IDEX_stall  out  1  hold ID/EX register
IDEX_flush  out  1  load NOP into ID/EX
EXMEM_stall  out  1  hold EX/MEM register
MEMWB_flush  out  1  load NOP into MEM/WB
mem_err  out  1  registered one-cycle pulse: dmem access timed out
perf_stall_cnt  out  CNT_W  cycles with pc_stall=1
perf_flush_cnt  out  CNT_W  redirect flush events

Behaviour:
- Clocking and reset: single clk domain. rst is synchronous, active-high.
- Reset state: FSM=RUN, wait_cnt=0, mem_err=0, perf counters=0.
- Outputs while rst=1: all *_stall=0, IFID_flush=IDEX_flush=MEMWB_flush=1 (pipeline cleared).
- FSM states: RUN, MEM_WAIT, ABORT. Stall/flush outputs are combinational from state + inputs (zero latency). mem_err is registered.
- Hazard terms:
  - load_use = EX_ValidReg[0] && EX_RegSrc==1 && EX_rd!=0 && ((ID_ValidReg[1] && ID_rs1==EX_rd) || (ID_ValidReg[2] && ID_rs2==EX_rd)).
  - wait_need = MEM_dmem_req && !dmem_ack.
- Freeze (state MEM_WAIT and no ack, or RUN with wait_need):
  - pc_stall=IFID_stall=IDEX_stall=EXMEM_stall=1, MEMWB_flush=1.
  - IFID_flush=IDEX_flush=0.
  - Redirect and load-use are ignored; EX is held, so EX_redirect is re-evaluated after release.
- RUN priority: freeze > redirect > load-use > none.
  - Redirect: IFID_flush=1, IDEX_flush=1, pc_stall=0.
  - Load-use: pc_stall=1, IFID_stall=1, IDEX_flush=1; exactly one bubble per hazard. The next cycle the load is in MEM and load_use re-evaluates false.
  - None: all outputs 0.
- Transitions:
  - RUN -> MEM_WAIT when wait_need; wait_cnt <= 1.
  - MEM_WAIT + dmem_ack -> RUN. Outputs in the ack cycle equal RUN evaluation with wait_need=0, so the pipeline advances that cycle.
  - MEM_WAIT, no ack, wait_cnt==MEM_TIMEOUT-1 -> ABORT. Otherwise wait_cnt++.
  - ABORT (1 cycle): no stalls, MEMWB_flush=1 (access dropped), IFID/IDEX flush=0, mem_err<=1 registered for this one cycle; -> RUN.
- An ack arriving in ABORT is ignored.
- A same-cycle ack in RUN causes no stall.
- Back-to-back accesses re-enter MEM_WAIT directly from the ack cycle's RUN evaluation on the next cycle.
- rst asserted mid-MEM_WAIT: next cycle is RUN with wait_cnt=0, and no mem_err pulse.

Optional Feature:
HAZARD_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle pc_stall=1 (not during rst).
  - perf_flush_cnt increments on each redirect flush cycle.
  - Both wrap modulo 2^CNT_W and are cleared by rst.
- Undefined: no counter flops; both outputs are tied to 0.

Test Plan:
- Load-use: EX lw x5 (EX_RegSrc=1, EX_ValidReg=3'b001), ID add using rs1=x5 -> 1 cycle pc_stall=IFID_stall=IDEX_flush=1, then all 0. Repeat with rd=x0 -> no stall.
- Redirect and load-use same cycle -> IFID_flush=IDEX_flush=1, pc_stall=0, IFID_stall=0.
- MEM_dmem_req=1, ack after 3 cycles -> freeze outputs for 3 cycles, ack cycle all stalls 0, state RUN; redirect held high during the wait flushes only in the ack cycle.
- MEM_TIMEOUT=8, no ack -> 8 freeze cycles, then one ABORT cycle with MEMWB_flush=1 and no stalls, mem_err=1 for exactly 1 cycle, then RUN.
- rst pulsed in the 2nd wait cycle -> outputs show reset values during rst, then RUN, no mem_err, a fresh wait restarts count at 1.
- HAZARD_PERF_EN: 1 load-use + 3-cycle wait + 2 redirects -> perf_stall_cnt=4, perf_flush_cnt=2; undefined -> both 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM pipeline status in, stall/flush controls and perf counters out.
// master = pipeline side driving status, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic [2:0]       ID_ValidReg;
  logic [4:0]       EX_rd;
  logic [2:0]       EX_ValidReg;
  logic [1:0]       EX_RegSrc;
  logic             EX_redirect;
  logic             MEM_dmem_req;
  logic             dmem_ack;
  logic             pc_stall;
  logic             IFID_stall;
  logic             IFID_flush;
  logic             IDEX_stall;
  logic             IDEX_flush;
  logic             EXMEM_stall;
  logic             MEMWB_flush;
  logic             mem_err;
  logic [CNT_W-1:0] perf_stall_cnt;
  logic [CNT_W-1:0] perf_flush_cnt;

  modport master (
    output ID_rs1, ID_rs2, ID_ValidReg, EX_rd, EX_ValidReg, EX_RegSrc,
           EX_redirect, MEM_dmem_req, dmem_ack,
    input  pc_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush,
           EXMEM_stall, MEMWB_flush, mem_err, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_ValidReg, EX_rd, EX_ValidReg, EX_RegSrc,
           EX_redirect, MEM_dmem_req, dmem_ack,
    output pc_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush,
           EXMEM_stall, MEMWB_flush, mem_err, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubble, redirect flush, dmem-wait freeze.
// Define HAZARD_PERF_EN to build the stall/flush performance counters; otherwise they read 0.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ABORT} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            abort_nxt;
  logic            mem_err;
  logic            load_use, wait_need;
  logic            freeze, eval_run;
  logic            pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic            exmem_stall, memwb_flush;
  logic            unused_bits;

  assign unused_bits = ^{hz.ID_ValidReg[0], hz.EX_ValidReg[2:1]};

  // Load data is only forwardable from WB, so a consumer directly behind a load must wait one cycle.
  assign load_use = hz.EX_ValidReg[0] && (hz.EX_RegSrc == 2'd1) && (hz.EX_rd != 5'd0) &&
                    ((hz.ID_ValidReg[1] && (hz.ID_rs1 == hz.EX_rd)) ||
                     (hz.ID_ValidReg[2] && (hz.ID_rs2 == hz.EX_rd)));
  assign wait_need = hz.MEM_dmem_req && !hz.dmem_ack;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    abort_nxt    = 1'b0;
    freeze       = 1'b0;
    eval_run     = 1'b0;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_flush  = 1'b0;

    case (state)
      RUN: begin
        if (wait_need) begin
          freeze       = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WC_W'(1);
        end else begin
          eval_run = 1'b1;
        end
      end
      MEM_WAIT: begin
        // The ack cycle behaves as RUN with no pending access, so the pipeline advances immediately.
        if (hz.dmem_ack) begin
          eval_run     = 1'b1;
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          freeze       = 1'b1;
          state_nxt    = ABORT;
          wait_cnt_nxt = '0;
          abort_nxt    = 1'b1;
        end else begin
          freeze       = 1'b1;
          wait_cnt_nxt = wait_cnt + WC_W'(1);
        end
      end
      ABORT: begin
        memwb_flush = 1'b1;
        state_nxt   = RUN;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    if (freeze) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_flush = 1'b1;
    end else if (eval_run) begin
      if (hz.EX_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end

    if (rst) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= abort_nxt;
    end
  end

  assign hz.pc_stall    = pc_stall;
  assign hz.IFID_stall  = ifid_stall;
  assign hz.IFID_flush  = ifid_flush;
  assign hz.IDEX_stall  = idex_stall;
  assign hz.IDEX_flush  = idex_flush;
  assign hz.EXMEM_stall = exmem_stall;
  assign hz.MEMWB_flush = memwb_flush;
  assign hz.mem_err     = mem_err;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Outside reset, IFID_flush can only come from a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall)   stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.perf_stall_cnt = stall_cnt;
  assign hz.perf_flush_cnt = flush_cnt;
`else
  assign hz.perf_stall_cnt = '0;
  assign hz.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle expected control vectors queued at drive time, checked mid-cycle.
module tb_hazard_ctrl;

  localparam int CNT_W = 32;
  localparam int TMO   = 8;

  // {pc_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall, MEMWB_flush, mem_err}
  localparam logic [7:0] E_NONE = 8'b0000_0000;
  localparam logic [7:0] E_RST  = 8'b0010_1010;
  localparam logic [7:0] E_LU   = 8'b1100_1000;
  localparam logic [7:0] E_RED  = 8'b0010_1000;
  localparam logic [7:0] E_FRZ  = 8'b1101_0110;
  localparam logic [7:0] E_ABT  = 8'b0000_0011;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_stall;
  int   exp_flush;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #90000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] idv,
                        input logic [4:0] rd, input logic [2:0] exv, input logic [1:0] src,
                        input logic red, input logic req, input logic ack);
    hz.ID_rs1       = rs1;
    hz.ID_rs2       = rs2;
    hz.ID_ValidReg  = idv;
    hz.EX_rd        = rd;
    hz.EX_ValidReg  = exv;
    hz.EX_RegSrc    = src;
    hz.EX_redirect  = red;
    hz.MEM_dmem_req = req;
    hz.dmem_ack     = ack;
  endtask

  // Queue the expected controls for the cycle just driven, compare mid-cycle, then advance one clock.
  task automatic step(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    logic [7:0] want;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    if (!rst && exp[7]) exp_stall++;
    if (!rst && exp[5]) exp_flush++;
    @(negedge clk);
    obs  = {hz.pc_stall, hz.IFID_stall, hz.IFID_flush, hz.IDEX_stall, hz.IDEX_flush,
            hz.EXMEM_stall, hz.MEMWB_flush, hz.mem_err};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", t, obs, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_stall = 0;
    exp_flush = 0;
    rst       = 1'b1;
    set_in(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    step("rst0", E_RST);
    hz.MEM_dmem_req = 1'b1;
    hz.EX_redirect  = 1'b1;
    step("rst1_inputs_masked", E_RST);
    rst = 1'b0;
    set_in(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    check_cnt("perf_stall_reset", hz.perf_stall_cnt, '0);
    check_cnt("perf_flush_reset", hz.perf_flush_cnt, '0);
    step("idle", E_NONE);

    // Load-use detection and its non-hazard variants
    set_in(5'd5, 5'd3, 3'b011, 5'd5, 3'b001, 2'd1, 1'b0, 1'b0, 1'b0);
    step("lu_rs1", E_LU);
    set_in(5'd5, 5'd3, 3'b011, 5'd0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    step("lu_bubble_after", E_NONE);
    set_in(5'd3, 5'd9, 3'b101, 5'd9, 3'b001, 2'd1, 1'b0, 1'b0, 1'b0);
    step("lu_rs2", E_LU);
    set_in(5'd0, 5'd3, 3'b011, 5'd0, 3'b001, 2'd1, 1'b0, 1'b0, 1'b0);
    step("lu_x0", E_NONE);
    set_in(5'd5, 5'd3, 3'b011, 5'd5, 3'b001, 2'd0, 1'b0, 1'b0, 1'b0);
    step("alu_no_lu", E_NONE);
    set_in(5'd5, 5'd3, 3'b001, 5'd5, 3'b001, 2'd1, 1'b0, 1'b0, 1'b0);
    step("rs1_unused", E_NONE);

    // Redirect outranks load-use
    set_in(5'd5, 5'd3, 3'b011, 5'd5, 3'b001, 2'd1, 1'b1, 1'b0, 1'b0);
    step("redirect_and_lu", E_RED);
    set_in(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 2'd0, 1'b1, 1'b0, 1'b0);
    step("redirect", E_RED);

    // 3-cycle dmem wait with redirect and load-use held; redirect acts only in the ack cycle
    set_in(5'd5, 5'd3, 3'b011, 5'd5, 3'b001, 2'd1, 1'b1, 1'b1, 1'b0);
    step("wait0", E_FRZ);
    step("wait1", E_FRZ);
    step("wait2", E_FRZ);
    hz.dmem_ack = 1'b1;
    step("wait_ack_redirect", E_RED);
    set_in(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    step("after_wait_run", E_NONE);

    // Same-cycle ack, then back-to-back accesses
    set_in(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 2'd0, 1'b0, 1'b1, 1'b1);
    step("ack_same_cycle", E_NONE);
    hz.dmem_ack = 1'b0;
    step("b2b_first_req", E_FRZ);
    hz.dmem_ack = 1'b1;
    step("b2b_first_ack", E_NONE);
    hz.dmem_ack = 1'b0;
    step("b2b_second_req", E_FRZ);
    hz.dmem_ack = 1'b1;
    step("b2b_second_ack", E_NONE);
    set_in(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    step("b2b_idle", E_NONE);

    // Timeout: TMO frozen cycles, one ABORT cycle that ignores a late ack, back to RUN
    hz.MEM_dmem_req = 1'b1;
    for (int i = 0; i < TMO; i++) step($sformatf("tmo_freeze%0d", i), E_FRZ);
    hz.dmem_ack = 1'b1;
    step("tmo_abort", E_ABT);
    set_in(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    step("tmo_run", E_NONE);

    // Reset during the 2nd wait cycle, then a fresh full timeout
    hz.MEM_dmem_req = 1'b1;
    step("rstw_freeze0", E_FRZ);
    rst = 1'b1;
    step("rstw_in_reset", E_RST);
    rst = 1'b0;
    hz.MEM_dmem_req = 1'b0;
    step("rstw_run", E_NONE);
    hz.MEM_dmem_req = 1'b1;
    for (int i = 0; i < TMO; i++) step($sformatf("rstw_tmo_freeze%0d", i), E_FRZ);
    hz.MEM_dmem_req = 1'b0;
    step("rstw_tmo_abort", E_ABT);
    step("rstw_tmo_run", E_NONE);

`ifdef HAZARD_PERF_EN
    check_cnt("perf_stall_cnt", hz.perf_stall_cnt, CNT_W'(exp_stall));
    check_cnt("perf_flush_cnt", hz.perf_flush_cnt, CNT_W'(exp_flush));
`else
    check_cnt("perf_stall_cnt", hz.perf_stall_cnt, '0);
    check_cnt("perf_flush_cnt", hz.perf_flush_cnt, '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
